// File: rtl/ccd_fifo_pkg.sv
// Shared definitions for the CCD FIFO bank reader/writer: FSM encoding,
// pointer width helper and the word counter width.
package ccd_fifo_pkg;

  localparam int WORDS_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_WAIT = 2'd2;
  localparam state_t S_HOLD = 2'd3;

  // Width of a lane pointer; a single lane still needs one bit.
  function automatic int ptr_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ccd_rr_pointer.sv
// Wrapping round-robin lane pointer, shared by the FIFO reader and writer.
// ptr_inc is the lane after ptr, exposed so callers can look ahead.
module ccd_rr_pointer
  import ccd_fifo_pkg::*;
#(
  parameter int NUM = 16,
  parameter int W   = ptr_width(NUM)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  output logic [W-1:0] ptr,
  output logic [W-1:0] ptr_inc
);

  localparam logic [W-1:0] LAST = W'(NUM - 1);

  // Explicit compare so non-power-of-two lane counts wrap correctly.
  assign ptr_inc = (ptr == LAST) ? '0 : ptr + W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_inc;
    end
  end

endmodule

// File: rtl/ccd_fifo_reader.sv
// Read-side drain of the CCD FIFO bank: round-robin lane visits, one read
// per word, merged into a single lane-tagged valid/ready stream.
module ccd_fifo_reader
  import ccd_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_FIFO   = 16,
  parameter int RD_LATENCY = 1,
  parameter int SKIP_EMPTY = 0
) (
  input  logic                          rd_clk,
  input  logic                          rd_rst,
  input  logic                          reader_en,
  input  logic                          empty      [NUM_FIFO],
  output logic                          rd_en      [NUM_FIFO],
  input  logic [DATA_WIDTH-1:0]         rd_data    [NUM_FIFO],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ptr_width(NUM_FIFO)-1:0] out_idx,
  output logic [WORDS_W-1:0]            words_read,
  output logic [1:0]                    dbg_state
);

  localparam int IDX_W = ptr_width(NUM_FIFO);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LATENCY - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W-1:0] req_lane;
  logic             ptr_adv;
  logic [CNT_W-1:0] wait_cnt;
  logic             handshake;

  // Output handshake: a word transfers in any cycle with out_valid && out_ready;
  // once raised, out_valid and its payload hold until that transfer happens.
  assign out_valid = (state == S_HOLD);
  assign handshake = out_valid && out_ready;
  assign dbg_state = state;

  ccd_rr_pointer #(
    .NUM (NUM_FIFO),
    .W   (IDX_W)
  ) u_ptr (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .advance (ptr_adv),
    .ptr     (ptr),
    .ptr_inc (ptr_inc)
  );

  always_comb begin
    state_nxt = state;
    ptr_adv   = 1'b0;
    req_lane  = ptr;
    case (state)
      S_IDLE: begin
        if (reader_en) begin
          if (!empty[ptr]) begin
            state_nxt = S_REQ;
          end else if (SKIP_EMPTY != 0) begin
            ptr_adv = 1'b1;
          end
        end
      end
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == '0) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // Decide on the next lane now so its read strobe lands right after the handoff.
        if (out_ready) begin
          ptr_adv   = 1'b1;
          req_lane  = ptr_inc;
          state_nxt = (reader_en && !empty[ptr_inc]) ? S_REQ : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      out_data   <= '0;
      out_idx    <= '0;
      words_read <= '0;
      for (int i = 0; i < NUM_FIFO; i++) rd_en[i] <= 1'b0;
    end else begin
      state <= state_nxt;
      for (int i = 0; i < NUM_FIFO; i++) begin
        rd_en[i] <= (state_nxt == S_REQ) && (req_lane == IDX_W'(i));
      end
      if (state == S_REQ) begin
        wait_cnt <= LAT_INIT;
      end else if (state == S_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
      if (state == S_WAIT && wait_cnt == '0) begin
        out_data <= rd_data[ptr];
        out_idx  <= ptr;
      end
      if (handshake) words_read <= words_read + WORDS_W'(1);
    end
  end

endmodule

// File: tb/tb_ccd_fifo_reader.sv
// Bench for ccd_fifo_reader: a strict-order instance (latency 3) and a
// skip-empty instance (latency 1), each fed by a queue model of its FIFO bank.
module tb_ccd_fifo_reader;
  import ccd_fifo_pkg::*;

  localparam int DW     = 16;
  localparam int NF     = 5;
  localparam int IW     = 3;
  localparam int LAT_A  = 3;
  localparam int LAT_B  = 1;
  localparam int MAXLAT = 3;

  // ---------------- clock / reset ----------------
  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  logic reader_en = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // ---------------- DUT wiring (index 0 = strict, 1 = skip) ----------------
  logic          empty_a [NF], empty_b [NF], rd_en_a [NF], rd_en_b [NF];
  logic [DW-1:0] rd_data_a [NF], rd_data_b [NF];
  logic          ov_a, ov_b;
  logic          ordy_a, ordy_b;
  logic [DW-1:0] od_a, od_b;
  logic [IW-1:0] oi_a, oi_b;
  logic [31:0]   wr_a, wr_b;
  logic [1:0]    st_a, st_b;

  logic          emp  [2][NF];
  logic [DW-1:0] rdat [2][NF];
  logic          ordy [2];
  logic          re   [2][NF];
  logic          ov   [2];
  logic [DW-1:0] od   [2];
  logic [IW-1:0] oi   [2];
  logic [31:0]   wr   [2];
  logic [1:0]    st   [2];

  always_comb begin
    for (int k = 0; k < NF; k++) begin
      empty_a[k]   = emp[0][k];
      empty_b[k]   = emp[1][k];
      rd_data_a[k] = rdat[0][k];
      rd_data_b[k] = rdat[1][k];
      re[0][k]     = rd_en_a[k];
      re[1][k]     = rd_en_b[k];
    end
    ordy_a = ordy[0];
    ordy_b = ordy[1];
    ov[0] = ov_a;  ov[1] = ov_b;
    od[0] = od_a;  od[1] = od_b;
    oi[0] = oi_a;  oi[1] = oi_b;
    wr[0] = wr_a;  wr[1] = wr_b;
    st[0] = st_a;  st[1] = st_b;
  end

  ccd_fifo_reader #(.DATA_WIDTH(DW), .NUM_FIFO(NF), .RD_LATENCY(LAT_A), .SKIP_EMPTY(0)) dut_a (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .reader_en(reader_en), .empty(empty_a), .rd_en(rd_en_a),
    .rd_data(rd_data_a), .out_valid(ov_a), .out_ready(ordy_a), .out_data(od_a), .out_idx(oi_a),
    .words_read(wr_a), .dbg_state(st_a));

  ccd_fifo_reader #(.DATA_WIDTH(DW), .NUM_FIFO(NF), .RD_LATENCY(LAT_B), .SKIP_EMPTY(1)) dut_b (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .reader_en(reader_en), .empty(empty_b), .rd_en(rd_en_b),
    .rd_data(rd_data_b), .out_valid(ov_b), .out_ready(ordy_b), .out_data(od_b), .out_idx(oi_b),
    .words_read(wr_b), .dbg_state(st_b));

  // ---------------- FIFO bank model and scoreboard state ----------------
  logic [DW-1:0] lane_q [2*NF][$];
  logic [DW-1:0] exp_q  [2*NF][$];
  logic [DW-1:0] dly    [2][NF][MAXLAT+1];
  logic [IW-1:0] idx_log_b [$];
  int            gap_log [2][$];
  int            last_rd [2];
  int            model_words [2];
  int            pushed [2];
  int            rd_pulses [2];
  logic          prev_any [2];
  logic          prev_stall [2];
  logic [DW-1:0] held_data [2];
  logic [IW-1:0] held_idx [2];
  logic          prev_ren;
  int            exp_ptr;
  int            cyc;
  logic [11:0]   seq_n;
  int            checks;
  int            errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] junk();
    return {4'hF, 12'($urandom)};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic refresh_empty();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NF; k++) emp[d][k] = (lane_q[d*NF+k].size() == 0);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NF; k++) begin
        lane_q[d*NF+k].delete();
        exp_q[d*NF+k].delete();
        for (int j = 0; j <= MAXLAT; j++) dly[d][k][j] = junk();
        rdat[d][k] = junk();
      end
      gap_log[d].delete();
      last_rd[d] = -1; model_words[d] = 0; pushed[d] = 0; rd_pulses[d] = 0;
      prev_any[d] = 1'b0; prev_stall[d] = 1'b0;
    end
    idx_log_b.delete();
    prev_ren = 1'b0;
    exp_ptr  = 0;
    refresh_empty();
  endtask

  // Writer side: each word is tagged with its lane and a running sequence number.
  task automatic push_word(input int d, input int k, output logic [DW-1:0] w);
    w = {4'(k), seq_n};
    seq_n++;
    lane_q[d*NF+k].push_back(w);
    exp_q[d*NF+k].push_back(w);
    pushed[d]++;
    refresh_empty();
  endtask

  // ---------------- monitor + FIFO read model (negedge) ----------------
  initial begin
    cyc = 0;
    forever begin
      @(negedge rd_clk);
      cyc++;
      if (!rd_rst) begin
        for (int d = 0; d < 2; d++) begin
          int n_hi;
          int lane;
          n_hi = 0;
          for (int k = 0; k < NF; k++) if (re[d][k]) n_hi++;
          chk("rd_en_at_most_one", 32'(n_hi <= 1), 32'd1);
          if (n_hi > 0) begin
            chk("rd_en_not_consecutive", 32'(prev_any[d]), 32'd0);
            chk("rd_en_needs_reader_en", 32'(prev_ren), 32'd1);
            if (last_rd[d] >= 0) gap_log[d].push_back(cyc - last_rd[d]);
            last_rd[d] = cyc;
          end
          if (prev_stall[d]) begin
            chk("stall_valid_held", 32'(ov[d]), 32'd1);
            chk("stall_data_held", 32'(od[d]), 32'(held_data[d]));
            chk("stall_idx_held", 32'(oi[d]), 32'(held_idx[d]));
          end
          chk("words_read", wr[d], 32'(model_words[d]));
          if (ov[d] && ordy[d]) begin
            lane = d*NF + int'(oi[d]);
            chk("out_idx_in_range", 32'(oi[d] < NF), 32'd1);
            if (oi[d] < NF) begin
              chk("word_expected", 32'(exp_q[lane].size() > 0), 32'd1);
              if (exp_q[lane].size() > 0) chk("out_data", 32'(od[d]), 32'(exp_q[lane].pop_front()));
            end
            if (d == 0) begin
              chk("strict_order_idx", 32'(oi[d]), 32'(exp_ptr));
              exp_ptr = (exp_ptr == NF-1) ? 0 : exp_ptr + 1;
            end else begin
              idx_log_b.push_back(oi[d]);
            end
            model_words[d]++;
          end
          prev_stall[d] = ov[d] && !ordy[d];
          held_data[d]  = od[d];
          held_idx[d]   = oi[d];
          for (int k = 0; k < NF; k++) begin
            for (int j = MAXLAT; j > 0; j--) dly[d][k][j] = dly[d][k][j-1];
            dly[d][k][0] = junk();
            if (re[d][k]) begin
              chk("read_of_nonempty_lane", 32'(lane_q[d*NF+k].size() > 0), 32'd1);
              if (lane_q[d*NF+k].size() > 0) dly[d][k][0] = lane_q[d*NF+k].pop_front();
              rd_pulses[d]++;
            end
            rdat[d][k] = dly[d][k][lat_of(d)];
          end
          prev_any[d] = (n_hi > 0);
        end
        prev_ren = reader_en;
        refresh_empty();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      int n_hi;
      n_hi = 0;
      for (int k = 0; k < NF; k++) if (re[d][k]) n_hi++;
      chk({tag, "_rd_en"}, 32'(n_hi), 32'd0);
      chk({tag, "_out_valid"}, 32'(ov[d]), 32'd0);
      chk({tag, "_out_idx"}, 32'(oi[d]), 32'd0);
      chk({tag, "_words_read"}, wr[d], 32'd0);
      chk({tag, "_state"}, 32'(st[d]), 32'(S_IDLE));
    end
  endtask

  // Called at posedge+1; asserts reset for one sampled edge, then releases.
  task automatic do_reset();
    rd_rst = 1'b1;
    clear_model();
    @(posedge rd_clk); #1;
    check_quiet("after_reset");
    chk("after_reset_out_data_a", 32'(od[0]), 32'd0);
    chk("after_reset_out_data_b", 32'(od[1]), 32'd0);
    rd_rst = 1'b0;
  endtask

  task automatic wait_rd_en(input int d, input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge rd_clk); #1;
      for (int k = 0; k < NF; k++) if (re[d][k]) seen = 1'b1;
    end
    chk({tag, "_rd_en_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input int d, input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge rd_clk); #1;
      if (ov[d]) seen = 1'b1;
    end
    chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] w0;
    logic [IW-1:0] exp_seq [5];
    int p0;
    int rem;
    checks = 0; errors = 0; seq_n = '0;
    ordy[0] = 1'b0; ordy[1] = 1'b0;
    clear_model();

    // Reset held three cycles with every lane empty.
    repeat (3) begin @(posedge rd_clk); #1; check_quiet("reset"); end
    rd_rst = 1'b0; reader_en = 1'b1;
    repeat (5) begin @(posedge rd_clk); #1; check_quiet("idle_all_empty"); end

    // Round-robin over preloaded lanes, lane 0 holding a second word.
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NF; k++) push_word(d, k, w);
      push_word(d, 0, w);
    end
    cycles(45);
    chk("rr_words_a", wr[0], 32'd6);
    chk("rr_words_b", wr[1], 32'd6);
    chk("rr_gap_count_a", 32'(gap_log[0].size()), 32'd5);
    chk("rr_gap_count_b", 32'(gap_log[1].size()), 32'd5);
    foreach (gap_log[0][i]) chk("rr_period_a", 32'(gap_log[0][i]), 32'(LAT_A + 2));
    foreach (gap_log[1][i]) chk("rr_period_b", 32'(gap_log[1][i]), 32'(LAT_B + 2));

    // Backpressure on the strict instance.
    do_reset();
    ordy[0] = 1'b0; ordy[1] = 1'b1; reader_en = 1'b1;
    push_word(0, 0, w0);
    for (int k = 1; k < NF; k++) push_word(0, k, w);
    wait_valid(0, "bp");
    repeat (10) begin
      int n_hi;
      @(posedge rd_clk); #1;
      n_hi = 0;
      for (int k = 0; k < NF; k++) if (re[0][k]) n_hi++;
      chk("bp_no_rd_en", 32'(n_hi), 32'd0);
      chk("bp_data_held", 32'(od[0]), 32'(w0));
      chk("bp_idx_held", 32'(oi[0]), 32'd0);
    end
    ordy[0] = 1'b1;
    @(posedge rd_clk); #1;
    chk("bp_rd_en_after_handshake", 32'(re[0][1]), 32'd1);
    chk("bp_valid_dropped", 32'(ov[0]), 32'd0);
    cycles(40);
    chk("bp_words_a", wr[0], 32'd5);

    // Lane 2 empty: strict instance stalls, skip instance goes around it.
    do_reset();
    ordy[0] = 1'b1; ordy[1] = 1'b1; reader_en = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NF; k++) if (k != 2) push_word(d, k, w);
    cycles(40);
    chk("empty_stall_words_a", wr[0], 32'd2);
    chk("empty_stall_reads_a", 32'(rd_pulses[0]), 32'd2);
    chk("empty_skip_words_b", wr[1], 32'd4);
    push_word(0, 2, w);
    push_word(1, 2, w);
    cycles(40);
    chk("empty_resume_words_a", wr[0], 32'd5);
    chk("empty_resume_words_b", wr[1], 32'd5);
    exp_seq = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd2};
    chk("skip_seq_len", 32'(idx_log_b.size()), 32'd5);
    foreach (exp_seq[i]) if (i < idx_log_b.size()) chk("skip_seq_idx", 32'(idx_log_b[i]), 32'(exp_seq[i]));

    // reader_en dropped while the strict instance waits on read data.
    do_reset();
    ordy[0] = 1'b1; ordy[1] = 1'b1; reader_en = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 2*NF; k++) push_word(d, k % NF, w);
    wait_rd_en(0, "en_drop");
    @(posedge rd_clk); #1;
    reader_en = 1'b0;
    p0 = rd_pulses[0];
    cycles(30);
    chk("en_drop_no_new_rd_en", 32'(rd_pulses[0] - p0), 32'd0);
    chk("en_drop_word_delivered", wr[0], 32'd1);
    chk("en_drop_valid_low", 32'(ov[0]), 32'd0);
    reader_en = 1'b1;
    cycles(70);
    chk("en_resume_words_a", wr[0], 32'(2*NF));

    // Reset while a word is in flight.
    do_reset();
    ordy[0] = 1'b1; ordy[1] = 1'b1; reader_en = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NF; k++) push_word(d, k, w);
    wait_rd_en(0, "mid_reset");
    @(posedge rd_clk); #1;
    chk("mid_reset_in_wait", 32'(st[0]), 32'(S_WAIT));
    do_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NF; k++) push_word(d, k, w);
    cycles(45);
    chk("mid_reset_fresh_words_a", wr[0], 32'd5);
    chk("mid_reset_fresh_words_b", wr[1], 32'd5);

    // Random traffic, then drain.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(posedge rd_clk); #1;
      reader_en = ($urandom_range(0, 9) != 0);
      for (int d = 0; d < 2; d++) begin
        ordy[d] = ($urandom_range(0, 9) < 7);
        for (int k = 0; k < NF; k++)
          if (lane_q[d*NF+k].size() < 6 && $urandom_range(0, 99) < 15) push_word(d, k, w);
      end
    end
    reader_en = 1'b1; ordy[0] = 1'b1; ordy[1] = 1'b1;
    cycles(300);
    chk("drain_strict_stops_on_empty", 32'(exp_q[exp_ptr].size()), 32'd0);
    rem = 0;
    for (int k = 0; k < NF; k++) rem += exp_q[k].size();
    chk("drain_words_a", wr[0], 32'(pushed[0] - rem));
    rem = 0;
    for (int k = 0; k < NF; k++) rem += exp_q[NF+k].size();
    chk("drain_skip_all_delivered", 32'(rem), 32'd0);
    chk("drain_words_b", wr[1], 32'(pushed[1]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccd_fifo_reader.md
# ccd_fifo_reader

Drains the bank of NUM_FIFO asynchronous FIFOs filled by the CCD FIFO writer, on the read-clock side. Visits lanes in round-robin order and issues one read strobe per word. Merges the words into a single valid/ready output stream tagged with the source lane index. Sits between the FIFO bank's read ports and the downstream convolution datapath.

## Interface
- DATA_WIDTH, 16, word width of every FIFO lane and of out_data
- NUM_FIFO, 16, number of FIFO lanes (>= 2, need not be a power of two)
- RD_LATENCY, 1, cycles from a sampled rd_en to valid rd_data (>= 1)
- SKIP_EMPTY, 0, 0 = strict order (wait on an empty lane); 1 = advance past empty lanes
- rd_clk  input  1  sole clock, all logic on posedge
- rd_rst  input  1  reset, synchronous, active-high
- reader_en  input  1  permits new read transactions
- empty  input  1 x [NUM_FIFO] unpacked  per-lane empty flag, rd_clk domain
- rd_en  output  1 x [NUM_FIFO] unpacked  per-lane read strobe, registered
- rd_data  input  DATA_WIDTH x [NUM_FIFO] unpacked  per-lane read data
- out_valid  output  1  out_data/out_idx valid
- out_ready  input  1  downstream accepts when high with out_valid
- out_data  output  DATA_WIDTH  captured word
- out_idx  output  $clog2(NUM_FIFO)  lane the word came from
- words_read  output  32  count of accepted output words, wraps at 2^32

## Operation
- State machine, one transaction outstanding at a time:
  - IDLE: if reader_en and ~empty[ptr], go to REQ. If reader_en, empty[ptr] and SKIP_EMPTY=1, ptr advances one lane per cycle and the FSM stays in IDLE. Otherwise it holds.
  - REQ: exactly one cycle. rd_en[ptr]=1, all other rd_en=0. Go to WAIT with wait counter = RD_LATENCY-1.
  - WAIT: count down. At counter 0, capture rd_data[ptr] into out_data and ptr into out_idx, then go to HOLD.
  - HOLD: out_valid=1. On out_ready:
    - ptr advances and words_read increments.
    - Next state is REQ if reader_en and the next lane is non-empty.
    - Otherwise next state is IDLE.
- Pointer wrap: NUM_FIFO-1 -> 0, explicit compare, never modulo on the raw width.
- empty is sampled only in IDLE and in HOLD's decision. A lane going empty in REQ/WAIT is not re-checked, because the read was already committed.
- reader_en deasserted during REQ/WAIT/HOLD: the in-flight word completes and is handed off, then the FSM goes to IDLE. No new rd_en is issued.
- With SKIP_EMPTY=0, output order equals the writer's round-robin order.
- out_data and out_idx stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: all rd_en=0, out_valid=0, out_data=0, out_idx=0, words_read=0, ptr=0, state IDLE.
- rd_rst mid-transaction discards any in-flight word. No rd_en is asserted in the cycle after rd_rst is sampled high.
- Sequence: rd_en is high in cycle t. rd_data is captured at the end of cycle t+RD_LATENCY. out_valid rises in cycle t+RD_LATENCY+1.
- Back-to-back with out_ready=1: the next rd_en is in the cycle after the handshake. Steady-state period is RD_LATENCY+2 cycles per word.
- rd_en is never high for two consecutive cycles. At most one lane's rd_en is high in any cycle.
- A handshake occurs in the cycle where out_valid & out_ready. out_valid drops in the next cycle unless a new word is captured in that same edge, which cannot happen.

## Structure
- Shared package ccd_fifo_pkg holds:
  - the state enum (IDLE, REQ, WAIT, HOLD);
  - the pointer-width function (max($clog2(NUM_FIFO),1));
  - the words_read width constant (32).
- Sub-module ccd_rr_pointer implements the wrapping lane pointer, with advance and sync reset. It is reusable by the writer side.
- Everything else stays in a single always_ff plus next-state logic in ccd_fifo_reader.

## Test plan
- Reset/idle: rd_rst high 3 cycles, all empty=1 -> every rd_en=0, out_valid=0, words_read=0, out_idx=0 throughout.
- Round-robin: NUM_FIFO=4, RD_LATENCY=1, all non-empty, lane k returns 0x100+k, out_ready=1 -> outputs 0x100,0x101,0x102,0x103,0x100. out_idx 0,1,2,3,0. rd_en pulses every 3 cycles. words_read=5.
- Backpressure: out_ready=0 for 10 cycles during HOLD -> out_data/out_idx stable, no rd_en pulses. Release -> the next rd_en follows one cycle after the handshake.
- Empty handling: lane 2 empty, SKIP_EMPTY=0 -> stalls at ptr=2 with no rd_en until empty[2]=0. Same stimulus with SKIP_EMPTY=1 -> sequence 0,1,3,0.
- reader_en drop in WAIT, RD_LATENCY=3 -> the pending word is still delivered, then no further rd_en. Reassert -> resumes at the next lane.
- Reset mid-op: rd_rst asserted in WAIT -> next cycle out_valid=0, ptr=0. The captured-but-undelivered word never appears.
